// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU I/D request lines, shared memory port and arbiter statistics.
// slave is the arbiter's view; master is the CPU/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
);
    localparam int LW = LINE_WORDS * WORD_SIZE;
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [LW-1:0]        i_data;
    logic                 i_readyM;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [LW-1:0]        d_wdata;
    logic [LW-1:0]        d_rdata;
    logic                 d_readyM;
    logic                 d_doneM;
    logic                 m_readM;
    logic                 m_writeM;
    logic [WORD_SIZE-1:0] m_address;
    logic [LW-1:0]        m_wdata;
    logic [LW-1:0]        m_rdata;
    logic                 m_readyM;
    logic                 m_doneM;
    logic                 grant_d;
    logic [WORD_SIZE-1:0] num_i_grant;
    logic [WORD_SIZE-1:0] num_d_grant;
    logic [WORD_SIZE-1:0] num_wait;
    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
               m_rdata, m_readyM, m_doneM,
        output i_data, i_readyM, d_rdata, d_readyM, d_doneM,
               m_readM, m_writeM, m_address, m_wdata,
               grant_d, num_i_grant, num_d_grant, num_wait
    );
    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
               m_rdata, m_readyM, m_doneM,
        input  i_data, i_readyM, d_rdata, d_readyM, d_doneM,
               m_readM, m_writeM, m_address, m_wdata,
               grant_d, num_i_grant, num_d_grant, num_wait
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-fetch and D-side line transactions onto one memory port.
// Fixed D-over-I priority by default; define ARB_ROUND_ROBIN_EN for last-owner-loses arbitration.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
) (
    input logic clk,
    input logic reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int LW = LINE_WORDS * WORD_SIZE;
    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);
    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;
    state_t               state_q, state_d;
    logic                 m_readM_q, m_readM_d, m_writeM_q, m_writeM_d;
    logic [WORD_SIZE-1:0] m_address_q, m_address_d;
    logic [LW-1:0]        m_wdata_q, m_wdata_d, i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic                 i_readyM_q, i_readyM_d, d_readyM_q, d_readyM_d, d_doneM_q, d_doneM_d;
    logic                 grant_d_q, grant_d_d;
    logic [WORD_SIZE-1:0] num_i_q, num_i_d, num_d_q, num_d_d, num_wait_q, num_wait_d;
    logic                 i_req, d_req, pick_d, wait_inc;
    // A side is blind to its own held request while its completion pulse is out.
    assign i_req = bus.i_readM & ~i_readyM_q;
    assign d_req = (bus.d_readM | bus.d_writeM) & ~(d_readyM_q | d_doneM_q);
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_d = d_req & (~i_req | ~grant_d_q);
`else
    assign pick_d = d_req;
`endif
    always_comb begin
        state_d     = state_q;
        m_readM_d   = m_readM_q;
        m_writeM_d  = m_writeM_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        i_data_d    = i_data_q;
        d_rdata_d   = d_rdata_q;
        i_readyM_d  = 1'b0;
        d_readyM_d  = 1'b0;
        d_doneM_d   = 1'b0;
        grant_d_d   = grant_d_q;
        num_i_d     = num_i_q;
        num_d_d     = num_d_q;
        wait_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                wait_inc = i_req & d_req;
                if (pick_d) begin
                    state_d     = bus.d_writeM ? D_WR : D_RD;
                    m_readM_d   = ~bus.d_writeM;
                    m_writeM_d  = bus.d_writeM;
                    m_address_d = bus.d_address;
                    m_wdata_d   = bus.d_writeM ? bus.d_wdata : m_wdata_q;
                    grant_d_d   = 1'b1;
                    num_d_d     = num_d_q + ONE;
                end else if (i_req) begin
                    state_d     = I_RD;
                    m_readM_d   = 1'b1;
                    m_address_d = bus.i_address;
                    grant_d_d   = 1'b0;
                    num_i_d     = num_i_q + ONE;
                end
            end
            I_RD: begin
                wait_inc = d_req & ~bus.m_readyM;
                if (bus.m_readyM) begin
                    state_d    = IDLE;
                    m_readM_d  = 1'b0;
                    i_data_d   = bus.m_rdata;
                    i_readyM_d = 1'b1;
                end
            end
            D_RD: begin
                wait_inc = i_req & ~bus.m_readyM;
                if (bus.m_readyM) begin
                    state_d    = IDLE;
                    m_readM_d  = 1'b0;
                    d_rdata_d  = bus.m_rdata;
                    d_readyM_d = 1'b1;
                end
            end
            D_WR: begin
                wait_inc = i_req & ~bus.m_doneM;
                if (bus.m_doneM) begin
                    state_d    = IDLE;
                    m_writeM_d = 1'b0;
                    d_doneM_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        num_wait_d = num_wait_q + {{(WORD_SIZE-1){1'b0}}, wait_inc};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            m_readM_q   <= 1'b0;
            m_writeM_q  <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
            i_readyM_q  <= 1'b0;
            d_readyM_q  <= 1'b0;
            d_doneM_q   <= 1'b0;
            grant_d_q   <= 1'b0;
            num_i_q     <= '0;
            num_d_q     <= '0;
            num_wait_q  <= '0;
        end else begin
            state_q     <= state_d;
            m_readM_q   <= m_readM_d;
            m_writeM_q  <= m_writeM_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            i_data_q    <= i_data_d;
            d_rdata_q   <= d_rdata_d;
            i_readyM_q  <= i_readyM_d;
            d_readyM_q  <= d_readyM_d;
            d_doneM_q   <= d_doneM_d;
            grant_d_q   <= grant_d_d;
            num_i_q     <= num_i_d;
            num_d_q     <= num_d_d;
            num_wait_q  <= num_wait_d;
        end
    end
    assign bus.m_readM     = m_readM_q;
    assign bus.m_writeM    = m_writeM_q;
    assign bus.m_address   = m_address_q;
    assign bus.m_wdata     = m_wdata_q;
    assign bus.i_data      = i_data_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.i_readyM    = i_readyM_q;
    assign bus.d_readyM    = d_readyM_q;
    assign bus.d_doneM     = d_doneM_q;
    assign bus.grant_d     = grant_d_q;
    assign bus.num_i_grant = num_i_q;
    assign bus.num_d_grant = num_d_q;
    assign bus.num_wait    = num_wait_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle vectors for arbitration/handshake plus sequences against a 2-cycle memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.WORD_SIZE(16), .LINE_WORDS(4)) bus();
    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    logic auto_mode = 1'b0;
    logic tab_mr = 1'b0, tab_md = 1'b0;
    logic mdl_ready, mdl_done, wv;
    logic [63:0] mdl_rdata, wdat;
    logic [15:0] waddr;
    localparam logic [63:0] W = 64'h1234_5678_9ABC_DEF0;
    assign bus.m_readyM = auto_mode ? mdl_ready : tab_mr;
    assign bus.m_doneM  = auto_mode ? mdl_done : tab_md;
    assign bus.m_rdata  = auto_mode ? mdl_rdata : 64'hDEAD_BEEF_0000_0001;
    function automatic logic [63:0] line_of(input logic [15:0] a);
        return {a ^ 16'h1111, a ^ 16'h2222, a ^ 16'h4444, a ^ 16'h8888};
    endfunction
    // Memory answers on the second edge after a strobe appears, remembering the last write.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_ready <= 1'b0; mdl_done <= 1'b0; mdl_rdata <= '0;
            wv <= 1'b0; waddr <= '0; wdat <= '0;
        end else begin
            mdl_ready <= 1'b0;
            mdl_done  <= 1'b0;
            if (bus.m_readM && !mdl_ready) begin
                mdl_ready <= 1'b1;
                mdl_rdata <= (wv && waddr == bus.m_address) ? wdat : line_of(bus.m_address);
            end
            if (bus.m_writeM && !mdl_done) begin
                mdl_done <= 1'b1; wv <= 1'b1; waddr <= bus.m_address; wdat <= bus.m_wdata;
            end
        end
    end
    typedef struct {
        logic ir, dr, dw, mr, md;
        logic [5:0]  flags;
        logic [15:0] addr;
    } vec_t;
    vec_t vecs[17];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wait_for(input int sel, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = (sel == 0) ? bus.i_readyM : (sel == 1) ? bus.d_readyM : bus.d_doneM;
        end
        check(name, 64'(seen), 64'd1);
    endtask
    task automatic clear_inputs();
        bus.i_readM = 1'b0; bus.d_readM = 1'b0; bus.d_writeM = 1'b0;
        bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0;
        tab_mr = 1'b0; tab_md = 1'b0;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask
    function automatic logic [63:0] flags();
        return 64'({bus.m_readM, bus.m_writeM, bus.i_readyM, bus.d_readyM, bus.d_doneM, bus.grant_d});
    endfunction
    initial begin
        int cnt;
        bit seen, early_wr, wstable, d_seen;
        // ir dr dw mr md | {m_readM,m_writeM,i_readyM,d_readyM,d_doneM,grant_d} | m_address
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'b100000, 16'h0010};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'b100000, 16'h0010};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 6'b001000, 16'h0010};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 16'h0010};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 6'b100001, 16'h0020};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 6'b100001, 16'h0020};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 6'b000101, 16'h0020};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'b100000, 16'h0010};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 6'b100000, 16'h0010};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 6'b001000, 16'h0010};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'b000000, 16'h0010};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'b100000, 16'h0010};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 6'b001000, 16'h0010};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 6'b010001, 16'h0020};
        vecs[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 6'b010001, 16'h0020};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 6'b000011, 16'h0020};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000001, 16'h0020};
        clear_inputs();
        @(posedge clk); #1;
        check("reset flags", flags(), 64'd0);
        check("reset m_address", 64'(bus.m_address), 64'd0);
        check("reset m_wdata", bus.m_wdata, 64'd0);
        check("reset i_data", bus.i_data, 64'd0);
        check("reset d_rdata", bus.d_rdata, 64'd0);
        check("reset counters", {16'd0, bus.num_i_grant, bus.num_d_grant, bus.num_wait}, 64'd0);
        reset_n = 1'b1;
        bus.i_address = 16'h0010; bus.d_address = 16'h0020; bus.d_wdata = W;
        for (int k = 0; k < 17; k++) begin
            bus.i_readM = vecs[k].ir; bus.d_readM = vecs[k].dr; bus.d_writeM = vecs[k].dw;
            tab_mr = vecs[k].mr; tab_md = vecs[k].md;
            @(posedge clk); #1;
            check($sformatf("vec%0d flags", k), flags(), 64'(vecs[k].flags));
            check($sformatf("vec%0d m_address", k), 64'(bus.m_address), 64'(vecs[k].addr));
        end
        check("table m_wdata", bus.m_wdata, W);
        check("table num_i_grant", 64'(bus.num_i_grant), 64'd3);
        check("table num_d_grant", 64'(bus.num_d_grant), 64'd2);
        check("table num_wait", 64'(bus.num_wait), 64'd2);
        clear_inputs();
        auto_mode = 1'b1;
        do_reset();
        // Lone I read: strobe two cycles, one pulse, model data.
        bus.i_address = 16'h0010; bus.i_readM = 1'b1;
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.m_readM) cnt++;
            seen = bus.i_readyM;
        end
        bus.i_readM = 1'b0;
        check("s1 i_readyM seen", 64'(seen), 64'd1);
        check("s1 strobe cycles", 64'(cnt), 64'd2);
        check("s1 i_data", bus.i_data, line_of(16'h0010));
        check("s1 num_i_grant", 64'(bus.num_i_grant), 64'd1);
        check("s1 num_wait", 64'(bus.num_wait), 64'd0);
        @(posedge clk); #1;
        check("s1 single pulse", 64'(bus.i_readyM), 64'd0);
        // D write queued behind a busy I read.
        bus.i_address = 16'h0030; bus.i_readM = 1'b1;
        @(posedge clk); #1;
        bus.d_address = 16'h0020; bus.d_wdata = W; bus.d_writeM = 1'b1;
        early_wr = 1'b0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.m_writeM) early_wr = 1'b1;
            seen = bus.i_readyM;
        end
        bus.i_readM = 1'b0;
        check("s4 i_readyM seen", 64'(seen), 64'd1);
        check("s4 write before i_readyM", 64'(early_wr), 64'd0);
        check("s4 i_data", bus.i_data, line_of(16'h0030));
        @(posedge clk); #1;
        check("s4 write starts", 64'(bus.m_writeM), 64'd1);
        wstable = 1'b1; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.m_writeM && (bus.m_wdata !== W || bus.m_address !== 16'h0020)) wstable = 1'b0;
            @(posedge clk); #1;
            seen = bus.d_doneM;
        end
        bus.d_writeM = 1'b0;
        check("s4 d_doneM seen", 64'(seen), 64'd1);
        check("s4 m_wdata stable", 64'(wstable), 64'd1);
        @(posedge clk); #1;
        check("s4 d_doneM single", 64'(bus.d_doneM), 64'd0);
        bus.d_readM = 1'b1;
        wait_for(1, "s4 readback d_readyM");
        bus.d_readM = 1'b0;
        check("s4 readback data", bus.d_rdata, W);
        // Asynchronous reset in the middle of a D read.
        @(posedge clk); #1;
        bus.d_address = 16'h0040; bus.d_readM = 1'b1;
        @(posedge clk); #1;
        check("rst pre m_readM", 64'(bus.m_readM), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst flags", flags(), 64'd0);
        check("rst m_address", 64'(bus.m_address), 64'd0);
        check("rst d_rdata", bus.d_rdata, 64'd0);
        check("rst counters", {16'd0, bus.num_i_grant, bus.num_d_grant, bus.num_wait}, 64'd0);
        bus.d_readM = 1'b0;
        d_seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.d_readyM) d_seen = 1'b1; end
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (bus.d_readyM) d_seen = 1'b1; end
        check("rst no d_readyM", 64'(d_seen), 64'd0);
        bus.i_address = 16'h0050; bus.i_readM = 1'b1;
        wait_for(0, "rst i_readyM");
        bus.i_readM = 1'b0;
        check("rst i_data", bus.i_data, line_of(16'h0050));
        check("rst num_i_grant", 64'(bus.num_i_grant), 64'd1);
`ifdef ARB_ROUND_ROBIN_EN
        // Last owner D: simultaneous requests must go to I first.
        @(posedge clk); #1;
        bus.d_address = 16'h0060; bus.d_readM = 1'b1;
        wait_for(1, "rr prime d_readyM");
        bus.d_readM = 1'b0;
        @(posedge clk); #1;
        bus.i_address = 16'h0070; bus.i_readM = 1'b1; bus.d_readM = 1'b1;
        @(posedge clk); #1;
        check("rr first owner", {47'd0, bus.grant_d, bus.m_address}, 64'h0070);
        wait_for(0, "rr i_readyM");
        check("rr d not yet", 64'(bus.d_readyM), 64'd0);
        bus.i_readM = 1'b0;
        wait_for(1, "rr d_readyM");
        bus.d_readM = 1'b0;
        check("rr d_rdata", bus.d_rdata, line_of(16'h0060));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified line-wide memory port between the instruction-fetch side and the data side of the pipelined CPU. Both sides keep the i_/d_ request/ready protocol they already use toward memory. The block sits between the CPU and Memory and serialises all traffic. It grants one transaction at a time, latches address and write data, forwards the transaction to memory and routes the response back.

Parameters:
WORD_SIZE, 16, bits per word
LINE_WORDS, 4, words per memory transfer; the data bus is LINE_WORDS*WORD_SIZE bits

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
i_readM  input  1  I-side read request, level, held until i_readyM
i_address  input  WORD_SIZE  I-side line address
i_data  output  LINE_WORDS*WORD_SIZE  I-side read data, valid with i_readyM
i_readyM  output  1  one-cycle pulse: I read complete
d_readM  input  1  D-side read request, level
d_writeM  input  1  D-side write request, level
d_address  input  WORD_SIZE  D-side line address
d_wdata  input  LINE_WORDS*WORD_SIZE  D-side write data
d_rdata  output  LINE_WORDS*WORD_SIZE  D-side read data, valid with d_readyM
d_readyM  output  1  one-cycle pulse: D read complete
d_doneM  output  1  one-cycle pulse: D write complete
m_readM  output  1  memory read strobe
m_writeM  output  1  memory write strobe
m_address  output  WORD_SIZE  memory address
m_wdata  output  LINE_WORDS*WORD_SIZE  memory write data
m_rdata  input  LINE_WORDS*WORD_SIZE  memory read data
m_readyM  input  1  memory read data valid
m_doneM  input  1  memory write complete
grant_d  output  1  1 when the current or last owner is the D side
num_i_grant  output  WORD_SIZE  count of I grants
num_d_grant  output  WORD_SIZE  count of D grants
num_wait  output  WORD_SIZE  count of cycles a request waited

Behaviour:
- Reset: every output is 0, all data buses are 0 and the state is IDLE. Reset acts immediately at any time, including mid-transaction. An in-flight memory transaction is abandoned and no response is pulsed.
- States: IDLE, I_RD, D_RD, D_WR. All outputs are registered.
- IDLE: the arbiter samples the requests at the clock edge.
  - With a pending D request, go to D_WR if d_writeM is set, otherwise to D_RD. d_writeM wins over d_readM when both are set.
  - Otherwise, with i_readM, go to I_RD.
  - Default arbitration is fixed priority, D over I.
  - On grant, latch m_address and m_wdata (m_wdata only for writes), set m_readM or m_writeM, update grant_d and increment the owner's grant counter.
- Busy states: the strobe, m_address and m_wdata stay stable.
  - I_RD / D_RD: when m_readyM is sampled at 1, capture m_rdata into i_data or d_rdata, pulse i_readyM or d_readyM for the next cycle, drop m_readM and return to IDLE.
  - D_WR: when m_doneM is sampled at 1, pulse d_doneM, drop m_writeM and return to IDLE.
  - m_readyM in D_WR is ignored. m_doneM in a read state is ignored. Both are ignored in IDLE.
- Latency: a request sampled in IDLE at edge N drives the memory strobe after edge N. A memory completion sampled at edge M drives the requester pulse during cycle M+1. The next grant is at edge M+1 at the earliest.
- During its pulse cycle, the completing side's request is masked, so a request that is still held is not re-granted.
- Read data outputs hold their value until the next completion for that side.
- A requester that drops its request mid-transaction does not abort it. The transaction completes and the response is still pulsed.
- num_wait: +1 on each edge where some request is pending but not granted, either because the arbiter is busy or because that side lost arbitration in IDLE. It increments by at most 1 per cycle.
- All counters wrap modulo 2^WORD_SIZE.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both sides request in IDLE, the side not granted last wins; grant_d records the last owner. A single requester is always granted.
- Undefined: fixed D-over-I priority as above. Note that a continuous D stream can starve I in this mode.

Test Plan:
- Memory model with 2-cycle latency. I read of 0x0010 alone -> m_readM=1 and m_address=0x0010 for 2 cycles; i_readyM pulses once with the model's line; num_i_grant=1, num_wait=0.
- I and D both request reads on the same edge, feature off -> D is served first, then I; d_readyM pulses before i_readyM; num_wait=2.
- Same stimulus with ARB_ROUND_ROBIN_EN and last owner = D -> I is served first, then D.
- D write of 0x1234_5678_9ABC_DEF0 to 0x0020 while I is busy -> the write starts only after i_readyM; m_wdata is stable through D_WR; d_doneM pulses once; a following read of 0x0020 returns that data.
- Request held high through and after its i_readyM pulse -> no duplicate grant in the pulse cycle; a new grant follows on the next edge; num_i_grant=2.
- reset_n low mid D_RD -> outputs are 0 immediately, no d_readyM; after release an I read completes normally.
